// File: rtl/jk_excitation_driver.sv
// Inverse-JK excitation driver: accepts a target word, pulses j/k for one cycle,
// then waits for the q feedback to match. Build option JK_DRV_TOGGLE_EN selects toggle encoding.
module jk_excitation_driver #(
    parameter int WIDTH   = 4,
    parameter int TIMEOUT = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_target,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             done,
    output logic             err
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] DRIVE = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    logic [1:0]       state;
    logic [WIDTH-1:0] tgt;
    logic [7:0]       cnt;
    logic [WIDTH-1:0] chg, j_nx, k_nx;
    logic             accept, match, last;

    // The excitation is computed from the live q_fb at the accept edge, so the
    // j/k registers themselves carry the snapshot into the DRIVE cycle.
    assign chg = in_target ^ q_fb;
`ifdef JK_DRV_TOGGLE_EN
    assign j_nx = chg;
    assign k_nx = chg;
`else
    assign j_nx = chg & in_target;
    assign k_nx = chg & ~in_target;
`endif

    assign in_ready = (state == IDLE);
    assign accept   = in_valid && in_ready;
    assign match    = (q_fb == tgt);
    assign last     = (cnt == LAST_CNT);
    // Completion is flagged inside the CHECK cycle itself; a pending reset suppresses it.
    assign done     = !reset && (state == CHECK) && (match || last);
    assign err      = done && !match;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            tgt   <= '0;
            cnt   <= '0;
            j     <= '0;
            k     <= '0;
        end else begin
            j <= '0;
            k <= '0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        tgt   <= in_target;
                        j     <= j_nx;
                        k     <= k_nx;
                        state <= DRIVE;
                    end
                end
                DRIVE: begin
                    cnt   <= '0;
                    state <= CHECK;
                end
                CHECK: begin
                    if (match || last) state <= IDLE;
                    else               cnt   <= cnt + 8'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_jk_excitation_driver.sv
// Directed bench for jk_excitation_driver with a behavioural JK bank on q_fb.
module tb_jk_excitation_driver;

    localparam int W = 4;

    logic         clk = 0;
    logic         reset;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_target;
    logic [W-1:0] q_fb;
    logic [W-1:0] j, k;
    logic         done, err;

    logic [W-1:0] bank_q;
    logic         stuck, preset_en;
    logic [W-1:0] preset_val;

    int n_chk = 0;
    int n_pass = 0;

    jk_excitation_driver #(.WIDTH(W), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_target(in_target), .q_fb(q_fb), .j(j), .k(k), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // JK bank model: set/reset/toggle/hold per bit
    always_ff @(posedge clk) begin
        if (preset_en) bank_q <= preset_val;
        else
            for (int b = 0; b < W; b++)
                case ({j[b], k[b]})
                    2'b10:   bank_q[b] <= 1'b1;
                    2'b01:   bank_q[b] <= 1'b0;
                    2'b11:   bank_q[b] <= ~bank_q[b];
                    default: bank_q[b] <= bank_q[b];
                endcase
    end
    assign q_fb = stuck ? '0 : bank_q;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_bank(input logic [W-1:0] v);
        preset_en = 1; preset_val = v;
        tick();
        preset_en = 0;
    endtask

    task automatic run(input string nm, input logic [W-1:0] q0, input logic [W-1:0] t,
                       input logic [W-1:0] ej, input logic [W-1:0] ek);
        load_bank(q0);
        chk({nm, ".ready_idle"}, in_ready, 1);
        in_valid = 1; in_target = t;
        tick();
        // DRIVE: extra valid and a different target must be ignored
        in_target = ~t;
        chk({nm, ".ready_drive"}, in_ready, 0);
        chk({nm, ".j"}, j, ej);
        chk({nm, ".k"}, k, ek);
        chk({nm, ".done_drive"}, done, 0);
        tick();
        in_valid = 0;
        chk({nm, ".done"}, done, 1);
        chk({nm, ".err"}, err, 0);
        chk({nm, ".q"}, q_fb, t);
        chk({nm, ".jk_check"}, {j, k}, 0);
        tick();
        chk({nm, ".ready_after"}, in_ready, 1);
        chk({nm, ".done_after"}, done, 0);
        chk({nm, ".q_hold"}, q_fb, t);
    endtask

    initial begin
        reset = 1; in_valid = 0; in_target = '0; stuck = 0; preset_en = 0; preset_val = '0;
        tick(); tick();
        chk("rst.j", j, 0);
        chk("rst.k", k, 0);
        chk("rst.done", done, 0);
        chk("rst.err", err, 0);
        reset = 0;
        tick();
        chk("rst.ready", in_ready, 1);

        run("basic", 4'b0000, 4'b1010, 4'b1010, 4'b0000);
`ifdef JK_DRV_TOGGLE_EN
        run("mixed", 4'b1100, 4'b0110, 4'b1010, 4'b1010);
`else
        run("mixed", 4'b1100, 4'b0110, 4'b0010, 4'b1000);
`endif
        run("nochg", 4'b0101, 4'b0101, 4'b0000, 4'b0000);

        // Timeout: feedback stuck at zero
        load_bank(4'b0000);
        stuck = 1;
        in_valid = 1; in_target = 4'b1111;
        tick();
        in_valid = 0;
        chk("to.j", j, 4'b1111);
        tick();
        for (int c = 1; c <= 3; c++) begin
            chk($sformatf("to.done_c%0d", c), done, 0);
            chk($sformatf("to.ready_c%0d", c), in_ready, 0);
            tick();
        end
        chk("to.done", done, 1);
        chk("to.err", err, 1);
        tick();
        chk("to.ready", in_ready, 1);
        chk("to.done_after", done, 0);

        // Reset during CHECK
        in_valid = 1; in_target = 4'b1111;
        tick();
        in_valid = 0;
        tick();
        chk("rm.in_check", in_ready, 0);
        reset = 1;
        #1;
        chk("rm.no_done", done, 0);
        tick();
        chk("rm.no_done2", done, 0);
        chk("rm.idle", in_ready, 1);
        chk("rm.jk", {j, k}, 0);
        reset = 0;
        stuck = 0;
        tick();
        chk("rm.ready", in_ready, 1);
        run("post", 4'b0000, 4'b0001, 4'b0001, 4'b0000);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
